// File: rtl/systolic_skew_feeder.sv
// Skewing feeder for an N x N systolic MAC array: lane i is delayed by i extra
// cycles and carries per-lane cal_en / cal_done strobes aligned with its data.

module skew_lane #(
   parameter int W     = 16,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_en,
   input  logic         in_done,
   output logic [W-1:0] out_data,
   output logic         out_en,
   output logic         out_done
);

   logic [DEPTH-1:0][W-1:0] data_pipe;
   logic [DEPTH-1:0]        vld_pipe;
   logic [DEPTH-1:0]        done_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_pipe <= '0;
         vld_pipe  <= '0;
         done_pipe <= '0;
      end else begin
         data_pipe[0] <= in_data;
         vld_pipe[0]  <= in_en;
         done_pipe[0] <= in_done;
         for (int s = 1; s < DEPTH; s++) begin
            data_pipe[s] <= data_pipe[s-1];
            vld_pipe[s]  <= vld_pipe[s-1];
            done_pipe[s] <= done_pipe[s-1];
         end
      end
   end

   assign out_data = vld_pipe[DEPTH-1] ? data_pipe[DEPTH-1] : '0;
   assign out_en   = vld_pipe[DEPTH-1];
   assign out_done = done_pipe[DEPTH-1];

endmodule

module systolic_skew_feeder #(
   parameter int N      = 4,
   parameter int IN_LEN = 8,
   parameter int MAX_K  = 16
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_last,
   input  logic [N*IN_LEN-1:0]   s_west,
   input  logic [N*IN_LEN-1:0]   s_north,
   output logic [N*IN_LEN-1:0]   west_out,
   output logic [N*IN_LEN-1:0]   north_out,
   output logic [N-1:0]          lane_cal_en,
   output logic [N-1:0]          lane_cal_done,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  len_err
);

   localparam int KW = $clog2(MAX_K + 1);
   localparam int DW = $clog2(N + 2);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

   state_t        state, state_nx;
   logic [KW-1:0] k, k_nx, k_step;
   logic [DW-1:0] drain_cnt, drain_nx;
   logic          len_err_nx;
   logic          rst_seen;
   logic          accept;
   logic          inject_done;

   assign accept = s_valid & s_ready;
   assign k_step = (state == IDLE) ? KW'(1) : k + KW'(1);

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         k         <= '0;
         drain_cnt <= '0;
         len_err   <= 1'b0;
         rst_seen  <= 1'b0;
      end else begin
         state     <= state_nx;
         k         <= k_nx;
         drain_cnt <= drain_nx;
         len_err   <= len_err_nx;
         rst_seen  <= 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      k_nx       = k;
      drain_nx   = drain_cnt;
      len_err_nx = 1'b0;
      case (state)
         IDLE, FEED: begin
            if (accept) begin
               k_nx = k_step;
               if (s_last || (k_step == KW'(MAX_K))) begin
                  state_nx   = DRAIN;
                  drain_nx   = DW'(N + 1);
                  len_err_nx = !s_last;
               end else begin
                  state_nx = FEED;
               end
            end
         end
         DRAIN: begin
            drain_nx = drain_cnt - DW'(1);
            if (drain_cnt <= DW'(1)) begin
               state_nx = IDLE;
               drain_nx = '0;
               k_nx     = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // The done marker rides stage 0 in the first DRAIN cycle, right behind the last beat.
   always_comb begin
      s_ready     = rst_seen && (state != DRAIN);
      busy        = (state != IDLE);
      inject_done = (state == DRAIN) && (drain_cnt == DW'(N + 1));
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [2*IN_LEN-1:0] lane_in, lane_out;

      assign lane_in = accept ? {s_north[i*IN_LEN +: IN_LEN], s_west[i*IN_LEN +: IN_LEN]} : '0;

      skew_lane #(.W(2*IN_LEN), .DEPTH(i+1)) u_lane (
         .clk      (clk),
         .rst_n    (sys_rst_n),
         .in_data  (lane_in),
         .in_en    (accept),
         .in_done  (inject_done),
         .out_data (lane_out),
         .out_en   (lane_cal_en[i]),
         .out_done (lane_cal_done[i])
      );

      assign west_out[i*IN_LEN +: IN_LEN]  = lane_out[IN_LEN-1:0];
      assign north_out[i*IN_LEN +: IN_LEN] = lane_out[2*IN_LEN-1:IN_LEN];
   end

   assign frame_done = lane_cal_done[N-1];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: reset, basic frame, bubble, MAX_K
// truncation, handshake through DRAIN and reset mid-frame.

module tb_systolic_skew_feeder;

   localparam int N      = 4;
   localparam int IN_LEN = 8;
   localparam int MAX_K  = 16;

   logic                clk       = 1'b0;
   logic                sys_rst_n = 1'b0;
   logic                s_valid   = 1'b0;
   logic                s_last    = 1'b0;
   logic [N*IN_LEN-1:0] s_west    = '0;
   logic [N*IN_LEN-1:0] s_north   = '0;
   logic                s_ready;
   logic [N*IN_LEN-1:0] west_out, north_out;
   logic [N-1:0]        lane_cal_en, lane_cal_done;
   logic                busy, frame_done, len_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   systolic_skew_feeder #(.N(N), .IN_LEN(IN_LEN), .MAX_K(MAX_K)) dut (
      .clk           (clk),
      .sys_rst_n     (sys_rst_n),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_last        (s_last),
      .s_west        (s_west),
      .s_north       (s_north),
      .west_out      (west_out),
      .north_out     (north_out),
      .lane_cal_en   (lane_cal_en),
      .lane_cal_done (lane_cal_done),
      .busy          (busy),
      .frame_done    (frame_done),
      .len_err       (len_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Lane l of beat b: west = 16*b+l, north = 0x40+16*b+l.
   task automatic set_beat(input int b, input bit last);
      for (int l = 0; l < N; l++) begin
         s_west[l*IN_LEN +: IN_LEN]  = 8'(16*b + l);
         s_north[l*IN_LEN +: IN_LEN] = 8'(8'h40 + 16*b + l);
      end
      s_valid = 1'b1;
      s_last  = last;
   endtask

   task automatic idle_in;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_west  = '0;
      s_north = '0;
   endtask

   initial begin
      int en_cnt [N];
      int lerr_cnt, rdy_low, fd_cnt, done_cnt, en0;

      // reset held with s_valid high
      set_beat(7, 1'b1);
      tick; tick;
      chk("rst_west",  west_out, 32'h0);
      chk("rst_north", north_out, 32'h0);
      chk("rst_en",    32'(lane_cal_en), 32'h0);
      chk("rst_done",  32'(lane_cal_done), 32'h0);
      chk("rst_ready", 32'(s_ready), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_fd",    32'(frame_done), 32'h0);
      chk("rst_lerr",  32'(len_err), 32'h0);
      idle_in;
      sys_rst_n = 1'b1;
      tick;
      chk("rel_ready", 32'(s_ready), 32'h1);
      chk("rel_busy",  32'(busy), 32'h0);

      // basic frame: beats 0,1,2 at edges 0,1,2
      set_beat(0, 1'b0); tick;
      chk("basic_en_c1", 32'(lane_cal_en), 32'h1);
      set_beat(1, 1'b0); tick;
      set_beat(2, 1'b1); tick;
      idle_in;
      chk("basic_w2_c3",   32'(west_out[23:16]), 32'h02);
      chk("basic_busy_c3", 32'(busy), 32'h1);
      chk("basic_rdy_c3",  32'(s_ready), 32'h0);
      tick;
      chk("basic_w2_c4", 32'(west_out[23:16]), 32'h12);
      chk("basic_n3_c4", 32'(north_out[31:24]), 32'h43);
      tick;
      chk("basic_w2_c5",   32'(west_out[23:16]), 32'h22);
      chk("basic_en_c5",   32'(lane_cal_en), 32'hC);
      chk("basic_done_c5", 32'(lane_cal_done), 32'h2);
      tick;
      chk("basic_done_c6", 32'(lane_cal_done), 32'h4);
      chk("basic_en_c6",   32'(lane_cal_en), 32'h8);
      chk("basic_w2_c6",   32'(west_out[23:16]), 32'h00);
      chk("basic_fd_c6",   32'(frame_done), 32'h0);
      tick;
      chk("basic_fd_c7",  32'(frame_done), 32'h1);
      chk("basic_rdy_c7", 32'(s_ready), 32'h0);
      tick;
      chk("basic_rdy_c8",  32'(s_ready), 32'h1);
      chk("basic_busy_c8", 32'(busy), 32'h0);

      // bubble: beats at edges 0 and 2
      set_beat(1, 1'b0); tick;
      chk("bub_en_c1", 32'(lane_cal_en), 32'h1);
      idle_in; tick;
      chk("bub_en_c2",   32'(lane_cal_en), 32'h2);
      chk("bub_west_c2", west_out, 32'h00001100);
      chk("bub_busy_c2", 32'(busy), 32'h1);
      set_beat(2, 1'b1); tick;
      idle_in;
      chk("bub_en_c3",   32'(lane_cal_en), 32'h5);
      chk("bub_west_c3", west_out, 32'h00120020);
      tick;
      chk("bub_en_c4",   32'(lane_cal_en), 32'hA);
      chk("bub_done_c4", 32'(lane_cal_done), 32'h1);
      chk("bub_west_c4", west_out, 32'h13002100);
      tick;
      chk("bub_en_c5", 32'(lane_cal_en), 32'h4);
      tick;
      chk("bub_en_c6", 32'(lane_cal_en), 32'h8);
      tick;
      chk("bub_fd_c7", 32'(frame_done), 32'h1);
      tick;
      chk("bub_rdy_c8", 32'(s_ready), 32'h1);

      // MAX_K: pass 0 truncates without s_last, pass 1 ends normally on beat 16
      for (int pass = 0; pass < 2; pass++) begin
         for (int l = 0; l < N; l++) en_cnt[l] = 0;
         lerr_cnt = 0; rdy_low = 0; fd_cnt = 0;
         for (int c = 0; c < 26; c++) begin
            if (c < MAX_K) set_beat(c, (pass == 1) && (c == MAX_K - 1));
            else idle_in;
            tick;
            for (int l = 0; l < N; l++) en_cnt[l] += int'(lane_cal_en[l]);
            lerr_cnt += int'(len_err);
            rdy_low  += int'(!s_ready);
            fd_cnt   += int'(frame_done);
            if (c == MAX_K - 1) chk($sformatf("maxk%0d_lerr_c16", pass), 32'(len_err), 32'(1 - pass));
         end
         chk($sformatf("maxk%0d_en0", pass),   32'(en_cnt[0]), 32'd16);
         chk($sformatf("maxk%0d_en3", pass),   32'(en_cnt[3]), 32'd16);
         chk($sformatf("maxk%0d_lerrn", pass), 32'(lerr_cnt), 32'(1 - pass));
         chk($sformatf("maxk%0d_drain", pass), 32'(rdy_low), 32'd5);
         chk($sformatf("maxk%0d_fd", pass),    32'(fd_cnt), 32'd1);
         chk($sformatf("maxk%0d_busy", pass),  32'(busy), 32'h0);
      end

      // handshake: s_valid held through DRAIN
      set_beat(3, 1'b1); tick;
      chk("hs_w0_c1",  32'(west_out[7:0]), 32'h30);
      chk("hs_rdy_c1", 32'(s_ready), 32'h0);
      set_beat(5, 1'b1);
      en0 = 0; rdy_low = 0;
      for (int c = 2; c <= 6; c++) begin
         tick;
         en0     += int'(lane_cal_en[0]);
         rdy_low += int'(!s_ready);
      end
      chk("hs_en0_drain", 32'(en0), 32'd0);
      chk("hs_rdylow",    32'(rdy_low), 32'd4);
      chk("hs_rdy_c6",    32'(s_ready), 32'h1);
      tick;
      idle_in;
      chk("hs_en0_c7", 32'(lane_cal_en[0]), 32'h1);
      chk("hs_w0_c7",  32'(west_out[7:0]), 32'h50);
      repeat (5) tick;
      chk("hs_rdy_c12", 32'(s_ready), 32'h1);

      // reset mid-frame
      set_beat(1, 1'b0); tick;
      set_beat(2, 1'b0); tick;
      idle_in;
      sys_rst_n = 1'b0;
      #1;
      chk("mrst_west",  west_out, 32'h0);
      chk("mrst_en",    32'(lane_cal_en), 32'h0);
      chk("mrst_ready", 32'(s_ready), 32'h0);
      chk("mrst_busy",  32'(busy), 32'h0);
      tick; tick;
      sys_rst_n = 1'b1;
      done_cnt = 0; fd_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick;
         done_cnt += $countones(lane_cal_done);
         fd_cnt   += int'(frame_done);
      end
      chk("mrst_done_after", 32'(done_cnt), 32'd0);
      chk("mrst_fd_after",   32'(fd_cnt), 32'd0);
      chk("mrst_ready_after", 32'(s_ready), 32'h1);
      chk("mrst_busy_after",  32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
